imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Inverse of the decode-side immediate generator: takes a 32-bit immediate plus an immediate-type select and packs it into the scattered RV32 instruction immediate fields of a caller-supplied base instruction word.
- Checks range and alignment, buffers results in a small FIFO, and counts good and bad requests.
- Sits in the NPC test/trace infrastructure: instruction stimulus generator, self-modifying-code tests, round-trip checks against the decoder.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >=2
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_sel  in  3  imm type: 000 U, 001 I, 010 S, 011 B, 100 J, 101 Zimm, 110/111 illegal
- in_imm  in  32  immediate value (two's complement; Zimm unsigned)
- in_base  in  32  instruction word; bits outside the selected imm fields are preserved
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  packed instruction
- out_err  out  2  00 ok, 01 range, 10 misaligned, 11 bad sel
- cnt_ok  out  CNT_W  ok requests packed
- cnt_err  out  CNT_W  requests with out_err != 00
- rt_fail  out  1  sticky round-trip mismatch (see Optional Feature)

Behaviour:
- Reset:
  - FIFO empty: out_valid=0, out_inst=0, out_err=00.
  - cnt_ok=0, cnt_err=0, rt_fail=0.
  - in_ready=1 in the first cycle after reset release.
- Field mapping (inst bits <- imm bits):
  - U: [31:12] <- [31:12]
  - I: [31:20] <- [11:0]
  - S: [31:25] <- [11:5]; [11:7] <- [4:0]
  - B: [31] <- [12]; [30:25] <- [10:5]; [11:8] <- [4:1]; [7] <- [11]
  - J: [31] <- [20]; [30:21] <- [10:1]; [20] <- [11]; [19:12] <- [19:12]
  - Zimm: [19:15] <- [4:0]
- Checks, priority bad sel > misaligned > range:
  - Bad sel: in_sel 110/111.
  - Misaligned: B or J with imm[0]=1.
  - Range:
    - U: imm[11:0]!=0
    - I/S: imm[31:11] not all equal
    - B: imm[31:12] not all equal
    - J: imm[31:20] not all equal
    - Zimm: imm[31:5]!=0
- On any error, out_inst = in_base unmodified.
- Latency: the encoder is combinational and its result is written into the FIFO on the accept edge. out_valid rises the following cycle at the earliest; no combinational in->out path.
- in_ready = (occupancy < DEPTH), decoded from registered state only, with no dependence on out_ready. When full, a same-cycle pop does not open the input.
- Pop on out_valid & out_ready; order strictly FIFO. out_inst/out_err hold stable while out_valid & !out_ready.
- Simultaneous push and pop when not full: occupancy unchanged, both take effect.
- Read/write pointers wrap modulo DEPTH.
- Counters increment on accept, not on pop, and saturate at 2^CNT_W-1.
- rst mid-operation: FIFO contents discarded, counters cleared next edge.

Optional Feature:
- Macro: IMM_PACK_ROUNDTRIP_EN.
- Defined:
  - An internal decoder re-extracts the immediate from each packed ok-result using the decode-side rules (sign-extend; Zimm zero-extend; B/J bit0=0; U low 12 bits = 0).
  - The result is compared with in_imm on the accept cycle; a mismatch sets rt_fail, which is sticky until rst.
- Undefined: rt_fail tied to 0; no decoder logic.

Test Plan:
- I-type: sel=001, imm=0xFFFFFFFF, base=0x00000013 -> out_inst=0xFFF00013, out_err=00, cnt_ok=1, out_valid one cycle after accept.
- B-type: sel=011, imm=0x00000008, base=0x00000063 -> 0x00000463. Same with imm=0x00000003 -> out_inst=0x00000063, out_err=10, cnt_err=1.
- J-type: sel=100, imm=0x00000800, base=0x0000006F -> 0x0010006F. Same with imm=0x00100000 -> err=01. sel=111 -> err=11, inst=base.
- Backpressure, DEPTH=2: out_ready=0, offer 3 requests -> in_ready low after 2 accepts, third held. Raise out_ready -> three outputs in issue order, no loss or duplication.
- Saturation and reset: CNT_W=4, 20 ok requests -> cnt_ok=15. Assert rst with 2 entries queued -> next cycle out_valid=0, counters 0, in_ready=1.
- With IMM_PACK_ROUNDTRIP_EN: 1000 random legal (sel, imm) pairs -> rt_fail stays 0.

Source files
------------

// File: rtl/imm_packer.sv
// imm_packer: packs a 32-bit immediate into the scattered RV32 immediate fields
// of a caller-supplied base instruction word, flags range/alignment/select
// errors, buffers results in a DEPTH-entry FIFO and keeps saturating ok/err
// request counters.
//
// Optional build macro: IMM_PACK_ROUNDTRIP_EN adds a decoder that re-extracts
// the immediate from each ok result and sets the sticky rt_fail on mismatch.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_sel               000 U, 001 I, 010 S, 011 B, 100 J, 101 Zimm, else illegal
//   in_imm, in_base      immediate value and base instruction word
//   out_valid/out_ready  FIFO head handshake
//   out_inst, out_err    packed instruction, 00 ok / 01 range / 10 misaligned / 11 bad sel
//   cnt_ok, cnt_err      saturating accept counters
//   rt_fail              sticky round-trip mismatch (0 unless macro defined)
module imm_packer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic             rt_fail
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  localparam logic [2:0] SelU = 3'b000;
  localparam logic [2:0] SelI = 3'b001;
  localparam logic [2:0] SelS = 3'b010;
  localparam logic [2:0] SelB = 3'b011;
  localparam logic [2:0] SelJ = 3'b100;
  localparam logic [2:0] SelZ = 3'b101;

  // Sign-extension checks: the upper bits must all be copies of the sign bit.
  logic fits_12, fits_13, fits_21;
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  logic [31:0] pack_inst, enc_inst;
  logic [1:0]  enc_err;
  logic        range_bad, misalign, bad_sel;

  always_comb begin
    pack_inst = in_base;
    range_bad = 1'b0;
    misalign  = 1'b0;
    bad_sel   = 1'b0;
    case (in_sel)
      SelU: begin
        pack_inst[31:12] = in_imm[31:12];
        range_bad        = |in_imm[11:0];
      end
      SelI: begin
        pack_inst[31:20] = in_imm[11:0];
        range_bad        = ~fits_12;
      end
      SelS: begin
        pack_inst[31:25] = in_imm[11:5];
        pack_inst[11:7]  = in_imm[4:0];
        range_bad        = ~fits_12;
      end
      SelB: begin
        pack_inst[31]    = in_imm[12];
        pack_inst[30:25] = in_imm[10:5];
        pack_inst[11:8]  = in_imm[4:1];
        pack_inst[7]     = in_imm[11];
        misalign         = in_imm[0];
        range_bad        = ~fits_13;
      end
      SelJ: begin
        pack_inst[31]    = in_imm[20];
        pack_inst[30:21] = in_imm[10:1];
        pack_inst[20]    = in_imm[11];
        pack_inst[19:12] = in_imm[19:12];
        misalign         = in_imm[0];
        range_bad        = ~fits_21;
      end
      SelZ: begin
        pack_inst[19:15] = in_imm[4:0];
        range_bad        = |in_imm[31:5];
      end
      default: bad_sel = 1'b1;
    endcase

    if (bad_sel)        enc_err = 2'b11;
    else if (misalign)  enc_err = 2'b10;
    else if (range_bad) enc_err = 2'b01;
    else                enc_err = 2'b00;

    enc_inst = (enc_err == 2'b00) ? pack_inst : in_base;
  end

  // Output FIFO
  logic [31:0]     mem_inst_q [DEPTH];
  logic [1:0]      mem_err_q  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;
  logic            push, pop;

  // Full is decided from registered occupancy only, so a pop never opens the input
  // in the same cycle.
  assign in_ready  = count_q < DepthCnt;
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= enc_inst;
      mem_err_q[wr_ptr_q]  <= enc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push) begin
        if (enc_err == 2'b00) begin
          if (cnt_ok_q != '1) cnt_ok_q <= cnt_ok_q + CNT_W'(1);
        end else begin
          if (cnt_err_q != '1) cnt_err_q <= cnt_err_q + CNT_W'(1);
        end
      end
    end
  end

  // Storage is not reset; gating keeps the empty-FIFO outputs at zero.
  assign out_inst = out_valid ? mem_inst_q[rd_ptr_q] : '0;
  assign out_err  = out_valid ? mem_err_q[rd_ptr_q]  : '0;
  assign cnt_ok   = cnt_ok_q;
  assign cnt_err  = cnt_err_q;

`ifdef IMM_PACK_ROUNDTRIP_EN
  logic [31:0] dec_imm;
  logic        rt_fail_q;

  // Decode-side extraction, applied to the packed word.
  always_comb begin
    dec_imm = '0;
    case (in_sel)
      SelU: dec_imm = {enc_inst[31:12], 12'b0};
      SelI: dec_imm = {{20{enc_inst[31]}}, enc_inst[31:20]};
      SelS: dec_imm = {{20{enc_inst[31]}}, enc_inst[31:25], enc_inst[11:7]};
      SelB: dec_imm = {{19{enc_inst[31]}}, enc_inst[31], enc_inst[7], enc_inst[30:25],
                       enc_inst[11:8], 1'b0};
      SelJ: dec_imm = {{11{enc_inst[31]}}, enc_inst[31], enc_inst[19:12], enc_inst[20],
                       enc_inst[30:21], 1'b0};
      SelZ: dec_imm = {27'b0, enc_inst[19:15]};
      default: dec_imm = in_imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rt_fail_q <= 1'b0;
    end else if (push && (enc_err == 2'b00) && (dec_imm != in_imm)) begin
      rt_fail_q <= 1'b1;
    end
  end

  assign rt_fail = rt_fail_q;
`else
  assign rt_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed test-plan cases plus randomized
// traffic scored against a behavioural model of the packing rules.
module tb_imm_packer;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [31:0]      in_imm;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;
  logic             rt_fail;

  imm_packer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_imm   (in_imm),
    .in_base  (in_base),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_err  (out_err),
    .cnt_ok   (cnt_ok),
    .cnt_err  (cnt_err),
    .rt_fail  (rt_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [33:0] exp_q[$];   // {err, inst}
  int          ok_cnt  = 0;
  int          err_cnt = 0;
  int          pops    = 0;
  logic        acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Copy imm[src_lo +: hi-lo+1] into w[hi:lo].
  function automatic logic [31:0] put(input logic [31:0] w, input int hi, input int lo,
                                      input logic [31:0] imm, input int src_lo);
    logic [31:0] r;
    r = w;
    for (int i = 0; i <= hi - lo; i++) r[lo + i] = imm[src_lo + i];
    return r;
  endfunction

  function automatic logic [33:0] model(input logic [2:0] sel, input logic [31:0] imm,
                                        input logic [31:0] base);
    int          s;
    logic [1:0]  e;
    logic [31:0] w;
    s = int'(imm);
    e = 2'b00;
    w = base;
    if (sel > 3'd5) e = 2'b11;
    else if ((sel == 3'd3 || sel == 3'd4) && (imm % 2 != 0)) e = 2'b10;
    else begin
      case (sel)
        3'd0:       if (imm % 4096 != 0) e = 2'b01;
        3'd1, 3'd2: if (s < -2048 || s > 2047) e = 2'b01;
        3'd3:       if (s < -4096 || s > 4095) e = 2'b01;
        3'd4:       if (s < -(1 << 20) || s > (1 << 20) - 1) e = 2'b01;
        default:    if (imm > 31) e = 2'b01;
      endcase
    end
    if (e == 2'b00) begin
      case (sel)
        3'd0: w = put(w, 31, 12, imm, 12);
        3'd1: w = put(w, 31, 20, imm, 0);
        3'd2: begin w = put(w, 31, 25, imm, 5); w = put(w, 11, 7, imm, 0); end
        3'd3: begin
          w = put(w, 31, 31, imm, 12); w = put(w, 30, 25, imm, 5);
          w = put(w, 11, 8, imm, 1);   w = put(w, 7, 7, imm, 11);
        end
        3'd4: begin
          w = put(w, 31, 31, imm, 20); w = put(w, 30, 21, imm, 1);
          w = put(w, 20, 20, imm, 11); w = put(w, 19, 12, imm, 12);
        end
        default: w = put(w, 19, 15, imm, 0);
      endcase
    end
    return {e, w};
  endfunction

  function automatic logic [31:0] gen_imm(input logic [2:0] sel);
    logic [31:0] v;
    int          r;
    v = $urandom;
    if ($urandom_range(3, 0) == 0) return v;
    case (sel)
      3'd0:       v[11:0] = '0;
      3'd1, 3'd2: begin r = int'($urandom_range(4095, 0)) - 2048; v = r; end
      3'd3:       begin r = (int'($urandom_range(4095, 0)) - 2048) * 2; v = r; end
      3'd4:       begin r = (int'($urandom_range(1048575, 0)) - 524288) * 2; v = r; end
      3'd5:       v = $urandom_range(31, 0);
      default:    v = $urandom;
    endcase
    return v;
  endfunction

  // One clock with scoreboard bookkeeping; called #1 after a rising edge.
  task automatic tick();
    logic [33:0] e;
    check("ready_vs_occ", in_ready, (exp_q.size() < DEPTH));
    check("valid_vs_occ", out_valid, (exp_q.size() != 0));
    acc = in_valid & in_ready;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("head_inst", out_inst, e[31:0]);
      check("head_err", out_err, e[33:32]);
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    if (acc) begin
      e = model(in_sel, in_imm, in_base);
      exp_q.push_back(e);
      if (e[33:32] == 2'b00) begin if (ok_cnt < CNT_MAX) ok_cnt++; end
      else if (err_cnt < CNT_MAX) err_cnt++;
    end
    @(posedge clk);
    #1;
    check("cnt_ok", cnt_ok, ok_cnt);
    check("cnt_err", cnt_err, err_cnt);
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    int n;
    in_valid = 1'b1;
    in_sel   = sel;
    in_imm   = imm;
    in_base  = base;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick();
      n++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drained", out_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_imm    = '0;
    in_base   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_err", out_err, 2'b00);
    check("rst_cnt_ok", cnt_ok, 0);
    check("rst_cnt_err", cnt_err, 0);
    check("rst_rt_fail", rt_fail, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Directed test-plan cases
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 3'b001; in_imm = 32'hFFFF_FFFF; in_base = 32'h13;
    #1;
    check("i_no_comb_path", out_valid, 1'b0);
    drive(3'b001, 32'hFFFF_FFFF, 32'h0000_0013);
    check("i_valid", out_valid, 1'b1);
    check("i_inst", out_inst, 32'hFFF0_0013);
    check("i_err", out_err, 2'b00);
    check("i_cnt_ok", cnt_ok, 1);

    drive(3'b011, 32'h0000_0008, 32'h0000_0063);
    check("b_inst", out_inst, 32'h0000_0463);
    check("b_err", out_err, 2'b00);
    drive(3'b011, 32'h0000_0003, 32'h0000_0063);
    check("b_mis_inst", out_inst, 32'h0000_0063);
    check("b_mis_err", out_err, 2'b10);
    check("b_mis_cnt_err", cnt_err, 1);

    drive(3'b100, 32'h0000_0800, 32'h0000_006F);
    check("j_inst", out_inst, 32'h0010_006F);
    drive(3'b100, 32'h0010_0000, 32'h0000_006F);
    check("j_range_err", out_err, 2'b01);
    check("j_range_inst", out_inst, 32'h0000_006F);
    drive(3'b111, 32'h0000_0004, 32'h1234_5677);
    check("bad_sel_err", out_err, 2'b11);
    check("bad_sel_inst", out_inst, 32'h1234_5677);
    check("bad_cnt_err", cnt_err, 3);
    drain();

    // Backpressure: two entries fill the FIFO, third request is held
    out_ready = 1'b0;
    pops = 0;
    drive(3'b001, 32'h0000_0001, 32'h0000_0013);
    drive(3'b010, 32'hFFFF_F800, 32'h0000_0023);
    in_valid = 1'b1; in_sel = 3'b101; in_imm = 32'h0000_001F; in_base = 32'h0000_0073;
    repeat (3) tick();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_held", acc, 1'b0);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin tick(); n++; end
      if (!acc) check("bp_accept_timeout", 1'b0, 1'b1);
    end
    drain();
    check("bp_pops", pops, 3);

    // Saturation of cnt_ok (CNT_W = 4)
    for (int i = 0; i < 20; i++) drive(3'b000, {$urandom_range(1048575, 0), 12'h0}, $urandom);
    check("sat_cnt_ok", cnt_ok, 15);
    drain();

    // Randomized traffic with random gaps and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_sel    = 3'($urandom_range(7, 0));
      in_imm    = gen_imm(in_sel);
      in_base   = $urandom;
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    drain();
    check("rt_fail_clear", rt_fail, 1'b0);

    // Reset with two entries queued
    out_ready = 1'b0;
    drive(3'b001, 32'h0000_0005, 32'h0000_0013);
    drive(3'b001, 32'h0000_0006, 32'h0000_0013);
    check("pre_rst_full", in_ready, 1'b0);
    do_reset();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_cnt_ok", cnt_ok, 0);
    check("mid_rst_cnt_err", cnt_err, 0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_inst", out_inst, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
